// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small write-side FIFO.
// Frames go out back-to-back while the FIFO holds data.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_AW      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         wr_data,
    input  logic               wr_en,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow,
    output logic               tx_serial,
    output logic               tx_active,
    output logic               tx_done
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [15:0] CLK_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] CNT_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state;
    logic [15:0]        clk_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   cnt_nxt;
    logic               push;
    logic               pop;
    logic               bit_end;

    assign bit_end = (clk_cnt == CLK_LAST);
    assign push    = wr_en && !full;
    assign pop     = !empty &&
                     (state == IDLE || (state == STOP && bit_end));

    always_comb begin
        cnt_nxt = fifo_count;
        if (push && !pop)
            cnt_nxt = fifo_count + CNT_ONE;
        else if (pop && !push)
            cnt_nxt = fifo_count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            fifo_count <= cnt_nxt;
            full       <= (cnt_nxt == CNT_FULL);
            empty      <= (cnt_nxt == '0);
            overflow   <= wr_en && full;
        end
    end

    // Line and status are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            tx_serial <= 1'b1;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    tx_serial <= 1'b1;
                    tx_active <= 1'b0;
                    if (pop) begin
                        shreg     <= mem[rd_ptr];
                        clk_cnt   <= '0;
                        bit_idx   <= '0;
                        tx_serial <= 1'b0;
                        tx_active <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt   <= '0;
                        tx_serial <= shreg[0];
                        shreg     <= shreg >> 1;
                        state     <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            tx_serial <= 1'b1;
                            state     <= STOP;
                        end else begin
                            tx_serial <= shreg[0];
                            shreg     <= shreg >> 1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        tx_done <= 1'b1;
                        if (pop) begin
                            shreg     <= mem[rd_ptr];
                            tx_serial <= 1'b0;
                            state     <= START;
                        end else begin
                            tx_active <= 1'b0;
                            state     <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and random checks of uart_tx_fifo against a
// behavioural serial-line decoder and byte queues.
module tb_uart_tx_fifo;

    localparam int CPB = 87;
    localparam int AW  = 2;

    logic          clk;
    logic          rst_n;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          full;
    logic          empty;
    logic [AW:0]   fifo_count;
    logic          overflow;
    logic          tx_serial;
    logic          tx_active;
    logic          tx_done;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_AW     (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .full      (full),
        .empty     (empty),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .tx_serial (tx_serial),
        .tx_active (tx_active),
        .tx_done   (tx_done)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] rx_q[$];
    int         fall_q[$];
    int         done_q[$];
    int         ovf_n = 0;
    int         act_falls = 0;
    int         ferr = 0;

    logic       line_prev = 1'b1;
    logic       act_prev = 1'b0;
    logic       cur;
    logic [7:0] rb;
    bit         ok;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Event monitor: done pulses, overflow pulses, tx_active drops.
    always begin
        @(negedge clk);
        if (tx_done === 1'b1) done_q.push_back(cyc);
        if (overflow === 1'b1) ovf_n++;
        if (act_prev && !tx_active) act_falls++;
        act_prev = tx_active;
    end

    // Serial decoder: each bit must hold CPB cycles unchanged.
    always begin
        @(negedge clk);
        if (rst_n && line_prev && !tx_serial) begin
            fall_q.push_back(cyc);
            ok  = 1'b1;
            cur = 1'b0;
            rb  = '0;
            for (int k = 1; k < 10 * CPB; k++) begin
                @(negedge clk);
                if (!rst_n) begin
                    ok = 1'b0;
                    break;
                end
                if (k % CPB == 0) begin
                    cur = tx_serial;
                    if (k / CPB >= 1 && k / CPB <= 8)
                        rb[k / CPB - 1] = cur;
                end else if (tx_serial !== cur) begin
                    ok = 1'b0;
                end
            end
            if (cur !== 1'b1) ok = 1'b0;
            if (ok) rx_q.push_back(rb);
            else ferr++;
        end
        line_prev = tx_serial;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rx_q.delete();
        fall_q.delete();
        done_q.delete();
        ovf_n = 0;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        wr_data = 8'($urandom);
    endtask

    task automatic wait_quiet(input int max, input string tag);
        int n = 0;
        while ((tx_active || !empty) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_quiet"}, 32'(tx_active || !empty), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic rx_is(input string tag, input int i,
                         input logic [7:0] exp);
        logic [31:0] v;
        v = (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hxxxx_xxxx;
        chk($sformatf("%s_rx%0d", tag, i), v, 32'(exp));
    endtask

    initial begin
        int w;
        int f;
        int n;
        int a0;
        int ec;
        logic [7:0] exp_q[$];
        logic [7:0] d;

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_serial", 32'(tx_serial), 1);
        chk("rst_active", 32'(tx_active), 0);
        chk("rst_done", 32'(tx_done), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_count", 32'(fifo_count), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte: latency, frame length, bit pattern.
        clr();
        w = cyc + 1;
        wr(8'hAB);
        wait_quiet(2000, "t1");
        chk("t1_nfall", fall_q.size(), 1);
        chk("t1_latency", fall_q[0] - w, 1);
        rx_is("t1", 0, 8'hAB);
        chk("t1_ndone", done_q.size(), 1);
        chk("t1_len", done_q[0] - fall_q[0], 870);
        chk("t1_active", 32'(tx_active), 0);

        // Back-to-back frames.
        clr();
        a0 = act_falls;
        wr(8'h3F);
        wr(8'h00);
        wr(8'hFF);
        wait_quiet(4000, "t2");
        rx_is("t2", 0, 8'h3F);
        rx_is("t2", 1, 8'h00);
        rx_is("t2", 2, 8'hFF);
        chk("t2_ndone", done_q.size(), 3);
        chk("t2_gap1", done_q[1] - done_q[0], 870);
        chk("t2_gap2", done_q[2] - done_q[1], 870);
        chk("t2_b2b1", fall_q[1], done_q[0]);
        chk("t2_b2b2", fall_q[2], done_q[1]);
        chk("t2_span", done_q[2] - fall_q[0], 2610);
        chk("t2_actdrop", act_falls - a0, 1);

        // Fill to full, one dropped write.
        clr();
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'(i + 1);
            wr_en   = 1'b1;
            @(negedge clk);
            ec = (i == 0) ? 1 : ((i < 4) ? i : 4);
            chk($sformatf("t3_cnt%0d", i), 32'(fifo_count), ec);
            chk($sformatf("t3_full%0d", i), 32'(full), 32'(ec == 4));
        end
        wr_en = 1'b0;
        wait_quiet(6000, "t3");
        chk("t3_ovf", ovf_n, 1);
        chk("t3_nrx", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) rx_is("t3", i, 8'(i + 1));

        // Loopback of two bytes with a gap.
        clr();
        wr(8'h3F);
        repeat (100) @(negedge clk);
        wr(8'hC5);
        wait_quiet(3000, "t4");
        rx_is("t4", 0, 8'h3F);
        rx_is("t4", 1, 8'hC5);
        chk("t4_ferr", ferr, 0);

        // Reset during data bit 4 with two bytes queued.
        clr();
        wr(8'h81);
        wr(8'h42);
        wr(8'h24);
        chk("t5_cnt", 32'(fifo_count), 2);
        n = 0;
        while (fall_q.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_started", fall_q.size(), 1);
        f = fall_q[0];
        n = 0;
        while (cyc != f + 5 * CPB + 20 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        #1;
        chk("t5_serial", 32'(tx_serial), 1);
        chk("t5_active", 32'(tx_active), 0);
        chk("t5_empty", 32'(empty), 1);
        chk("t5_count", 32'(fifo_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (1500) @(negedge clk);
        chk("t5_nfall", fall_q.size(), 1);
        chk("t5_nrx", rx_q.size(), 0);
        chk("t5_ndone", done_q.size(), 0);
        chk("t5_abort", ferr, 1);
        ferr = 0;

        // Write lands on the stop-completion edge: one idle cycle.
        clr();
        wr(8'hC3);
        n = 0;
        while (fall_q.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        f = (fall_q.size() > 0) ? fall_q[0] : cyc;
        n = 0;
        while (cyc != f + 869 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        wr(8'h55);
        chk("t6_done", 32'(tx_done), 1);
        chk("t6_idle", 32'(tx_active), 0);
        chk("t6_cnt", 32'(fifo_count), 1);
        @(negedge clk);
        chk("t6_act", 32'(tx_active), 1);
        chk("t6_start", 32'(tx_serial), 0);
        wait_quiet(2000, "t6");
        rx_is("t6", 0, 8'hC3);
        rx_is("t6", 1, 8'h55);
        chk("t6_gap", fall_q[1] - done_q[0], 1);

        // Random bursts that never exceed the FIFO depth.
        for (int b = 0; b < 3; b++) begin
            clr();
            exp_q.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                exp_q.push_back(d);
                wr(d);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_quiet(6000, $sformatf("rnd%0d", b));
            chk($sformatf("rnd%0d_n", b), rx_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size(); i++)
                rx_is($sformatf("rnd%0d", b), i, exp_q[i]);
        end
        chk("ferr_end", ferr, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
